// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared defaults and types for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int          CNT_W_DEF        = 24;
    localparam int unsigned DEFAULT_HALF_DEF = 32'd4194304;  // 2^22 -> ~1.19 Hz at 10 MHz
    localparam int          MAX_CH           = 16;

    typedef logic [CNT_W_DEF-1:0] half_t;

    localparam half_t DEFAULT_HALF_H = half_t'(DEFAULT_HALF_DEF);

endpackage

// File: rtl/clkdiv_multi_if.sv
// clkdiv_multi_if: control/status bundle for clkdiv_multi.
// master drives enables, sync and half-period writes; slave returns the waves.
interface clkdiv_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_half;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    modport master (output en, sync, wr_en, wr_ch, wr_half, input clk_out, tick);
    modport slave  (input en, sync, wr_en, wr_ch, wr_half, output clk_out, tick);

endinterface

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider slice (half-period H, down-counter C, output Q).
// Optional tick flop is built only when CLKDIV_TICK_EN is defined.
module clkdiv_channel import clkdiv_pkg::*; #(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF_DEF)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_half_i,
    output logic             q_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] h_q, h_d, c_q, c_d, h_new;
    logic             q_q, q_d, tog;

    // Next-state: restart/load reload the counter, H==0 parks the channel,
    // otherwise count down while enabled and toggle on terminal count.
    always_comb begin
        h_new = load_i ? load_half_i : h_q;
        h_d   = h_new;
        c_d   = c_q;
        q_d   = q_q;
        tog   = 1'b0;
        if (restart_i || load_i) begin
            // H-1 is only formed for non-zero H; a zero H parks C at 0.
            c_d = (h_new == '0) ? '0 : h_new - ONE;
            if (restart_i || h_new == '0) q_d = 1'b0;
        end else if (h_q == '0) begin
            c_d = '0;
            q_d = 1'b0;
        end else if (en_i) begin
            if (c_q == '0) begin
                tog = 1'b1;
                q_d = ~q_q;
                c_d = h_q - ONE;
            end else begin
                c_d = c_q - ONE;
            end
        end
    end

    // State registers with synchronous reset to the default half-period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q <= RST_HALF;
            c_q <= RST_HALF - ONE;
            q_q <= 1'b0;
        end else begin
            h_q <= h_d;
            c_q <= c_d;
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

`ifdef CLKDIV_TICK_EN
    logic tick_q;

    // Tick is registered alongside Q so both change on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) tick_q <= 1'b0;
        else       tick_q <= tog;
    end

    assign tick_o = tick_q;
`else
    assign tick_o = 1'b0;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NUM_CH programmable square-wave dividers on clk_10mhz with a
// shared phase-align sync. Define CLKDIV_TICK_EN to build the per-edge tick.
module clkdiv_multi import clkdiv_pkg::*; #(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input logic           clk_10mhz,
    input logic           rst,
    clkdiv_multi_if.slave bus
);

    localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

    logic [NUM_CH-1:0] ld;
    logic [NUM_CH-1:0] clk_out_w;
    logic [NUM_CH-1:0] tick_w;

    // Write decode: indices at or beyond NUM_CH match no channel.
    always_comb begin
        ld = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ld[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W    (CNT_W),
            .RST_HALF (RST_HALF)
        ) u_ch (
            .clk_i       (clk_10mhz),
            .rst_i       (rst),
            .en_i        (bus.en[g]),
            .restart_i   (bus.sync),
            .load_i      (ld[g]),
            .load_half_i (bus.wr_half),
            .q_o         (clk_out_w[g]),
            .tick_o      (tick_w[g])
        );
    end

    assign bus.clk_out = clk_out_w;
    assign bus.tick    = tick_w;

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: vector table, hand-written corner sequences and a random
// run checked against an event-time reference model of each channel.
module tb_clkdiv_multi;

    localparam int NCH = 5;   // 5 channels so wr_ch can address out-of-range indices
    localparam int CW  = 8;
    localparam int DEF = 40;
    localparam int CHW = $clog2(NCH);
    localparam logic [NCH-1:0] ALL = '1;

`ifdef CLKDIV_TICK_EN
    localparam bit TICK_EN = 1'b1;
`else
    localparam bit TICK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    clkdiv_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    clkdiv_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_HALF(DEF)) dut (
        .clk_10mhz (clk),
        .rst       (rst),
        .bus       (bus)
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: each channel remembers its half-period, level and the
    // absolute cycle of its next toggle; a disabled cycle pushes that out by one.
    longint         cyc = 0;
    int             m_half [NCH];
    longint         m_next [NCH];
    logic [NCH-1:0] m_lvl  = '0;
    logic [NCH-1:0] m_tick = '0;

    task automatic model_edge(input logic r, input logic [NCH-1:0] e, input logic s,
                              input logic w, input logic [CHW-1:0] ch, input logic [CW-1:0] h);
        cyc++;
        m_tick = '0;
        for (int i = 0; i < NCH; i++) begin
            bit ld;
            ld = w && (int'(ch) == i);
            if (r) begin
                m_half[i] = DEF;
                m_next[i] = cyc + DEF;
                m_lvl[i]  = 1'b0;
            end else if (s || ld) begin
                if (ld) m_half[i] = int'(h);
                m_next[i] = cyc + m_half[i];
                if (s || m_half[i] == 0) m_lvl[i] = 1'b0;
            end else if (m_half[i] == 0) begin
                m_lvl[i] = 1'b0;
            end else if (!e[i]) begin
                m_next[i]++;
            end else if (cyc == m_next[i]) begin
                m_lvl[i]  = ~m_lvl[i];
                m_tick[i] = TICK_EN;
                m_next[i] = cyc + m_half[i];
            end
        end
    endtask

    task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare the DUT with the model.
    task automatic step(input logic r, input logic [NCH-1:0] e, input logic s,
                        input logic w, input logic [CHW-1:0] ch, input logic [CW-1:0] h);
        rst         = r;
        bus.en      = e;
        bus.sync    = s;
        bus.wr_en   = w;
        bus.wr_ch   = ch;
        bus.wr_half = h;
        @(posedge clk);
        model_edge(r, e, s, w, ch, h);
        #1;
        chk("model_clk_out", bus.clk_out, m_lvl);
        chk("model_tick", bus.tick, m_tick);
    endtask

    typedef struct {
        logic           r;
        logic [NCH-1:0] e;
        logic           s;
        logic           w;
        logic [CHW-1:0] ch;
        logic [CW-1:0]  h;
        logic [NCH-1:0] xc;
        logic [NCH-1:0] xt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [NCH-1:0] e, input logic s,
                                input logic w, input logic [CHW-1:0] ch, input logic [CW-1:0] h,
                                input logic [NCH-1:0] xc, input logic [NCH-1:0] xt);
        vec_t v;
        v.r = r; v.e = e; v.s = s; v.w = w; v.ch = ch; v.h = h; v.xc = xc; v.xt = xt;
        return v;
    endfunction

    vec_t tbl [17];
    logic [NCH-1:0] en_r;

    initial begin
        bus.en = '0; bus.sync = 1'b0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_half = '0;

        // Short post-reset script on ch1/ch0 (other channels stay well short of H=40).
        tbl[0]  = mk(1'b0, ALL,      1'b0, 1'b1, 3'd1, 8'd2, 5'b00000, 5'b00000); // ch1 H=2
        tbl[1]  = mk(1'b0, ALL,      1'b0, 1'b0, 3'd0, 8'd0, 5'b00000, 5'b00000);
        tbl[2]  = mk(1'b0, ALL,      1'b0, 1'b0, 3'd0, 8'd0, 5'b00010, 5'b00010); // rise
        tbl[3]  = mk(1'b0, ALL,      1'b0, 1'b0, 3'd0, 8'd0, 5'b00010, 5'b00000);
        tbl[4]  = mk(1'b0, ALL,      1'b0, 1'b0, 3'd0, 8'd0, 5'b00000, 5'b00010); // fall
        tbl[5]  = mk(1'b0, 5'b11101, 1'b0, 1'b0, 3'd0, 8'd0, 5'b00000, 5'b00000); // ch1 frozen
        tbl[6]  = mk(1'b0, ALL,      1'b0, 1'b0, 3'd0, 8'd0, 5'b00000, 5'b00000);
        tbl[7]  = mk(1'b0, ALL,      1'b0, 1'b0, 3'd0, 8'd0, 5'b00010, 5'b00010); // late rise
        tbl[8]  = mk(1'b0, ALL,      1'b0, 1'b1, 3'd1, 8'd0, 5'b00000, 5'b00000); // H=0 while high
        tbl[9]  = mk(1'b0, ALL,      1'b0, 1'b0, 3'd0, 8'd0, 5'b00000, 5'b00000);
        tbl[10] = mk(1'b0, ALL,      1'b0, 1'b1, 3'd7, 8'd1, 5'b00000, 5'b00000); // out of range
        tbl[11] = mk(1'b0, ALL,      1'b1, 1'b1, 3'd0, 8'd1, 5'b00000, 5'b00000); // sync + ch0 H=1
        tbl[12] = mk(1'b0, ALL,      1'b0, 1'b0, 3'd0, 8'd0, 5'b00001, 5'b00001); // 5 MHz
        tbl[13] = mk(1'b0, ALL,      1'b0, 1'b0, 3'd0, 8'd0, 5'b00000, 5'b00001);
        tbl[14] = mk(1'b0, ALL,      1'b0, 1'b0, 3'd0, 8'd0, 5'b00001, 5'b00001);
        tbl[15] = mk(1'b1, ALL,      1'b0, 1'b0, 3'd0, 8'd0, 5'b00000, 5'b00000); // reset mid-run
        tbl[16] = mk(1'b0, ALL,      1'b0, 1'b0, 3'd0, 8'd0, 5'b00000, 5'b00000);

        step(1'b1, '0, 1'b0, 1'b0, '0, '0);
        chk("reset_clk_out", bus.clk_out, '0);
        chk("reset_tick", bus.tick, '0);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].w, tbl[i].ch, tbl[i].h);
            chk("vec_clk_out", bus.clk_out, tbl[i].xc);
            chk("vec_tick", bus.tick, tbl[i].xt & {NCH{TICK_EN}});
        end

        // Default half-period after reset: rise at 40, fall at 80.
        step(1'b1, ALL, 1'b0, 1'b0, '0, '0);
        for (int k = 1; k <= 80; k++) begin
            step(1'b0, ALL, 1'b0, 1'b0, '0, '0);
            if (k == 39) chk1("dflt_pre_rise", bus.clk_out[0], 1'b0);
            if (k == 40) chk1("dflt_rise", bus.clk_out[0], 1'b1);
            if (k == 40) chk1("dflt_tick", bus.tick[0], TICK_EN);
            if (k == 79) chk1("dflt_pre_fall", bus.clk_out[0], 1'b1);
            if (k == 80) chk1("dflt_fall", bus.clk_out[0], 1'b0);
        end

        // Phase alignment: ch2 H=5, ch3 H=7, then sync.
        step(1'b0, ALL, 1'b0, 1'b1, 3'd2, 8'd5);
        step(1'b0, ALL, 1'b0, 1'b1, 3'd3, 8'd7);
        step(1'b0, ALL, 1'b1, 1'b0, '0, '0);
        chk("sync_low", bus.clk_out & 5'b01100, '0);
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, ALL, 1'b0, 1'b0, '0, '0);
            if (k == 4) chk1("sync_ch2_pre", bus.clk_out[2], 1'b0);
            if (k == 5) chk1("sync_ch2_rise", bus.clk_out[2], 1'b1);
            if (k == 6) chk1("sync_ch3_pre", bus.clk_out[3], 1'b0);
            if (k == 7) chk1("sync_ch3_rise", bus.clk_out[3], 1'b1);
        end

        // Sync and write on the same edge: new H=2 governs the restart.
        step(1'b0, ALL, 1'b1, 1'b1, 3'd1, 8'd2);
        chk1("syncwr_low0", bus.clk_out[1], 1'b0);
        step(1'b0, ALL, 1'b0, 1'b0, '0, '0);
        chk1("syncwr_low1", bus.clk_out[1], 1'b0);
        step(1'b0, ALL, 1'b0, 1'b0, '0, '0);
        chk1("syncwr_rise", bus.clk_out[1], 1'b1);

        // Random traffic against the model.
        en_r = ALL;
        for (int k = 0; k < 3000; k++) begin
            logic r, s, w;
            logic [CHW-1:0] ch;
            logic [CW-1:0]  h;
            r  = ($urandom_range(0, 299) == 0);
            s  = ($urandom_range(0, 39) == 0);
            w  = ($urandom_range(0, 7) == 0);
            ch = CHW'($urandom_range(0, 7));
            h  = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 255)) : CW'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) en_r[$urandom_range(0, NCH-1)] ^= 1'b1;
            step(r, en_r, s, w, ch, h);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
